scope_sample_scaler: RTL and testbench
======================================

# scope_sample_scaler

Multi-channel pipelined converter from raw ADC sample words to clamped screen Y coordinates for the waveform display path. Per channel it applies DC or AC coupling (AC via a running-mean DC estimator), a selectable vertical gain, a signed vertical offset and saturation to the visible range. It sits between the ADC capture logic and the trace buffer/renderer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- NUM_CH, 2, number of input channels; CH_W = max(1, clog2(NUM_CH))
- IN_W, 16, input sample word width; the ADC code is left-justified
- ADC_BITS, 12, ADC code width; code = in_data[IN_W-1 -: ADC_BITS], unsigned
- OUT_W, 10, screen Y width
- Y_MAX, 479, largest legal Y (bottom row); 0 is the top row
- Y_CENTER, 240, Y for a zero centred sample at offset 0
- OFF_W, 10, per-channel signed offset width
- ACC_SHIFT, 8, DC estimator time constant as 2^ACC_SHIFT samples

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  sample present
- in_ready  out  1  block can accept
- in_ch  in  CH_W  channel of sample
- in_data  in  IN_W  raw sample word
- couple_in  in  NUM_CH  per channel: 1 = AC, 0 = DC
- scale_in  in  4*NUM_CH  per channel gain code; channel c is [4c+3:4c]
- offset_in  in  OFF_W*NUM_CH  per channel signed offset; positive moves the trace down
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_ch  out  CH_W  channel of result
- out_y  out  OUT_W  screen Y, 0..Y_MAX
- out_clip  out  1  result was saturated

## Operation
- Acceptance: in_valid && in_ready at a clk edge. couple_in, scale_in and offset_in for in_ch are captured on that same edge and travel with the sample.
- in_ch >= NUM_CH: the sample is accepted and discarded. It produces no output and leaves the estimator unchanged.
- Stage 1, centring:
  - MID = 2^(ADC_BITS-1).
  - DC coupling: c = code - MID.
  - AC coupling: c = code - (dc_est[ch] >> ACC_SHIFT).
  - c is signed, ADC_BITS+1 bits.
- DC estimator:
  - Per channel, ADC_BITS+ACC_SHIFT bits, reset value MID << ACC_SHIFT.
  - Updated on every valid stage-1 sample of that channel, in either coupling mode: dc_est += code - (dc_est >> ACC_SHIFT).
  - Same-channel back-to-back samples see the updated value; there is no hazard.
- Stage 2, gain: s = (c * K) >>> 6, arithmetic shift, rounding toward -inf. K is selected by the gain code:
  - 0 → 256, 1 → 128, 2 → 64 (unity), 3 → 32, 4 → 16, 5 → 8, 6 → 4, 7 → 2.
  - Codes 8-15 → 64.
- Stage 3, positioning:
  - y = Y_CENTER - s + offset, computed signed at full width.
  - y < 0 → out_y = 0, clip = 1.
  - y > Y_MAX → out_y = Y_MAX, clip = 1.
  - Otherwise out_y = y, clip = 0.
- Ordering: outputs leave in acceptance order, and the channel tag is preserved.

## Timing
- Latency: a sample accepted at edge k gives out_valid = 1 after edge k+3, provided there is no stall.
- Throughput: 1 sample/cycle.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - All pipeline registers, including the DC estimators, hold while stalled.
  - out_* stay stable until the output handshake completes.
- Pipeline bubbles carry valid = 0. Bubbles do not stall the pipe.
- Reset (rst_n = 0 at an edge) forces all stage valids and out_valid to 0; out_y, out_ch and out_clip to 0; every dc_est to MID << ACC_SHIFT.
  - Reset mid-stream drops every in-flight sample with no output.
  - in_ready = 1 on the first cycle after reset.
- Config changes take effect only for samples accepted after the change. In-flight samples keep the config captured at their acceptance.

## Test plan
- Default parameters throughout.
- Unity gain, DC coupling:
  - ch0, couple 0, scale 2, offset 0, in_data 0x8000 → out_y 240, clip 0, out_valid exactly 3 cycles after acceptance.
  - in_data 0xFFF0 → out_y 0, clip 1.
- Scale 7 and offset, DC coupling:
  - in_data 0xFFF0 → 240 - 63 = out_y 177.
  - in_data 0x0000 → out_y 304.
  - Same with offset +10 → 314; with offset -400 → 0, clip 1.
- AC coupling from reset:
  - ch1, couple 1, scale 5, first code 3000 → c = 952, s = 119, out_y 121.
  - Constant 3000 for 4096 samples → out_y converges to 240 ±1.
  - ch0's estimator is unchanged throughout.
- Backpressure:
  - Stream 10 alternating-channel samples; hold out_ready low for 5 cycles mid-stream.
  - Required: in_ready low during the stall, out_* stable, no loss or duplication, order and out_ch preserved.
- Invalid channel and reset:
  - in_ch = 2 → accepted, no output.
  - Assert rst_n = 0 with 3 samples in flight → none emerge, and every dc_est reads back 2048 << 8.

Source files
------------

// File: rtl/scope_sample_scaler.sv
// Multi-channel pipeline turning raw ADC words into clamped screen Y coordinates:
// centring (DC or running-mean AC), gain, offset and saturation, with valid/ready on both sides.
module scope_sample_scaler #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned ADC_BITS  = 12,
  parameter int unsigned OUT_W     = 10,
  parameter int unsigned Y_MAX     = 479,
  parameter int unsigned Y_CENTER  = 240,
  parameter int unsigned OFF_W     = 10,
  parameter int unsigned ACC_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [IN_W-1:0]         in_data,
  input  logic [NUM_CH-1:0]       couple_in,
  input  logic [4*NUM_CH-1:0]     scale_in,
  input  logic [OFF_W*NUM_CH-1:0] offset_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic [OUT_W-1:0]        out_y,
  output logic                    out_clip
);

  localparam int unsigned EST_W = ADC_BITS + ACC_SHIFT;
  localparam int unsigned C_W   = ADC_BITS + 1;
  localparam int unsigned P_W   = C_W + 9;
  localparam int unsigned S_W   = P_W - 6;
  localparam int unsigned Y_W   = ((S_W > OFF_W) ? S_W : OFF_W) + 2;
  localparam int unsigned MID   = 1 << (ADC_BITS - 1);

  localparam logic [EST_W-1:0]      EST_RST  = EST_W'(MID) << ACC_SHIFT;
  localparam logic signed [Y_W-1:0] YC       = Y_W'(Y_CENTER);
  localparam logic signed [Y_W-1:0] YM       = Y_W'(Y_MAX);
  localparam logic [OUT_W-1:0]      YM_OUT   = OUT_W'(Y_MAX);

  // Stage registers
  logic                    r_s1_valid, r_s2_valid, r_s3_valid, r_out_valid;
  logic [CH_W-1:0]         r_s1_ch, r_s2_ch, r_s3_ch, r_out_ch;
  logic [ADC_BITS-1:0]     r_s1_code;
  logic                    r_s1_couple;
  logic [3:0]              r_s1_scale, r_s2_scale;
  logic signed [OFF_W-1:0] r_s1_off, r_s2_off, r_s3_off;
  logic signed [C_W-1:0]   r_s2_c;
  logic signed [S_W-1:0]   r_s3_s;
  logic [OUT_W-1:0]        r_out_y;
  logic                    r_out_clip;
  logic [EST_W-1:0]        r_est [NUM_CH];

  logic                    w_adv;
  logic                    w_ch_ok;
  logic [EST_W-1:0]        w_est_cur;
  logic [EST_W-1:0]        w_est_next;
  logic [ADC_BITS-1:0]     w_mean;
  logic signed [C_W-1:0]   w_c;
  logic [3:0]              w_sh;
  logic signed [P_W-1:0]   w_prod;
  logic signed [S_W-1:0]   w_s;
  logic signed [Y_W-1:0]   w_y;
  logic [OUT_W-1:0]        w_y_clamped;
  logic                    w_clip;
  logic                    w_unused_prod;

  assign w_adv    = !(r_out_valid && !out_ready);
  assign in_ready = w_adv;

  // Out-of-range channels are only representable when NUM_CH is not a power of two.
  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign w_ch_ok = 1'b1;
  end else begin : g_ch_partial
    assign w_ch_ok = in_ch < CH_W'(NUM_CH);
  end

  if (IN_W > ADC_BITS) begin : g_lsb
    logic w_unused_lsb;
    assign w_unused_lsb = ^in_data[IN_W-ADC_BITS-1:0];
  end

  // Stage 1: centring and DC estimator update
  assign w_est_cur  = r_est[r_s1_ch];
  assign w_mean     = w_est_cur[EST_W-1:ACC_SHIFT];
  assign w_c        = $signed({1'b0, r_s1_code} - (r_s1_couple ? {1'b0, w_mean} : C_W'(MID)));
  assign w_est_next = w_est_cur + EST_W'(r_s1_code) - EST_W'(w_mean);

  // Stage 2: gain K = 2^(8-code) expressed as a left shift
  always_comb begin
    w_sh = 4'd6;
    case (r_s2_scale)
      4'd0: w_sh = 4'd8;
      4'd1: w_sh = 4'd7;
      4'd2: w_sh = 4'd6;
      4'd3: w_sh = 4'd5;
      4'd4: w_sh = 4'd4;
      4'd5: w_sh = 4'd3;
      4'd6: w_sh = 4'd2;
      4'd7: w_sh = 4'd1;
      default: w_sh = 4'd6;
    endcase
  end

  assign w_prod        = P_W'(r_s2_c) <<< w_sh;
  assign w_s           = w_prod[P_W-1:6];
  assign w_unused_prod = ^w_prod[5:0];

  // Stage 3: positioning and saturation
  assign w_y = YC - Y_W'(r_s3_s) + Y_W'(r_s3_off);

  always_comb begin
    w_y_clamped = w_y[OUT_W-1:0];
    w_clip      = 1'b0;
    if (w_y < 0) begin
      w_y_clamped = '0;
      w_clip      = 1'b1;
    end else if (w_y > YM) begin
      w_y_clamped = YM_OUT;
      w_clip      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_s1_ch     <= '0;
      r_s2_ch     <= '0;
      r_s3_ch     <= '0;
      r_out_ch    <= '0;
      r_s1_code   <= '0;
      r_s1_couple <= 1'b0;
      r_s1_scale  <= '0;
      r_s2_scale  <= '0;
      r_s1_off    <= '0;
      r_s2_off    <= '0;
      r_s3_off    <= '0;
      r_s2_c      <= '0;
      r_s3_s      <= '0;
      r_out_y     <= '0;
      r_out_clip  <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_est[i] <= EST_RST;
      end
    end else if (w_adv) begin
      r_s1_valid <= in_valid && w_ch_ok;
      if (in_valid && w_ch_ok) begin
        r_s1_ch     <= in_ch;
        r_s1_code   <= in_data[IN_W-1 -: ADC_BITS];
        r_s1_couple <= couple_in[in_ch];
        r_s1_scale  <= scale_in[4*in_ch +: 4];
        r_s1_off    <= $signed(offset_in[OFF_W*in_ch +: OFF_W]);
      end

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_ch          <= r_s1_ch;
        r_s2_c           <= w_c;
        r_s2_scale       <= r_s1_scale;
        r_s2_off         <= r_s1_off;
        r_est[r_s1_ch]   <= w_est_next;
      end

      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_ch  <= r_s2_ch;
        r_s3_s   <= w_s;
        r_s3_off <= r_s2_off;
      end

      r_out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_out_ch   <= r_s3_ch;
        r_out_y    <= w_y_clamped;
        r_out_clip <= w_clip;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_y     = r_out_y;
  assign out_clip  = r_out_clip;

endmodule

// File: tb/tb_scope_sample_scaler.sv
// Directed bench for scope_sample_scaler: a reference model pushes expected results at
// acceptance and a monitor pops and compares them at each output handshake.
module tb_scope_sample_scaler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_ch;
  logic [15:0] in_data;
  logic [1:0]  couple_in;
  logic [7:0]  scale_in;
  logic [19:0] offset_in;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_ch;
  logic [9:0]  out_y;
  logic        out_clip;

  typedef struct packed {
    logic [0:0] ch;
    logic [9:0] y;
    logic       clip;
  } exp_t;

  exp_t       q[$];
  int         est[2];
  int         checks = 0;
  int         errors = 0;
  logic [9:0] last_y;
  logic       last_clip;
  logic [0:0] last_ch;

  always #5 clk = ~clk;

  scope_sample_scaler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .couple_in (couple_in),
    .scale_in  (scale_in),
    .offset_in (offset_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_y     (out_y),
    .out_clip  (out_clip)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input int ch, input int data, input int cp, input int sc,
                            input int off);
    int   code, c, k, s, y;
    exp_t e;
    code = (data >> 4) & 'hFFF;
    c = cp ? code - (est[ch] >> 8) : code - 2048;
    est[ch] = est[ch] + code - (est[ch] >> 8);
    k = (sc < 8) ? (256 >> sc) : 64;
    s = (c * k) >>> 6;
    y = 240 - s + off;
    e.ch = ch[0];
    e.clip = (y < 0 || y > 479);
    if (y < 0) y = 0;
    if (y > 479) y = 479;
    e.y = 10'(y);
    q.push_back(e);
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input int ch, input int data, input int cp, input int sc, input int off);
    bit ok = 0;
    in_valid = 1'b1;
    in_ch = ch[0];
    in_data = 16'(data);
    couple_in[ch] = cp[0];
    scale_in[ch*4 +: 4] = 4'(sc);
    offset_in[ch*10 +: 10] = 10'(off);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      model_push(ch, data, cp, sc, off);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    est[0] = 2048 << 8;
    est[1] = 2048 << 8;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed ch=%0d y=%0d expected no output", out_ch, out_y);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("scoreboard", {out_ch, out_y, out_clip}, e);
        last_y = out_y;
        last_clip = out_clip;
        last_ch = out_ch;
      end
    end
  end

  initial begin
    logic [11:0] snap;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_ch = '0;
    in_data = '0;
    couple_in = '0;
    scale_in = '0;
    offset_in = '0;
    out_ready = 1'b1;
    est[0] = 2048 << 8;
    est[1] = 2048 << 8;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_clip", out_clip, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Unity gain, DC coupling, with latency check
    send(0, 'h8000, 0, 2, 0);
    repeat (3) begin
      @(negedge clk);
      chk("latency_early", out_valid, 0);
    end
    @(negedge clk);
    chk("latency_k3", out_valid, 1);
    drain();
    chk("unity_mid_y", last_y, 240);
    chk("unity_mid_clip", last_clip, 0);
    send(0, 'hFFF0, 0, 2, 0);
    drain();
    chk("unity_top_y", last_y, 0);
    chk("unity_top_clip", last_clip, 1);

    // Gain code 7 with offsets
    send(0, 'hFFF0, 0, 7, 0);
    drain();
    chk("g7_max_y", last_y, 177);
    send(0, 'h0000, 0, 7, 0);
    drain();
    chk("g7_min_y", last_y, 304);
    send(0, 'h0000, 0, 7, 10);
    drain();
    chk("g7_off10_y", last_y, 314);
    send(0, 'h0000, 0, 7, -400);
    drain();
    chk("g7_offneg_y", last_y, 0);
    chk("g7_offneg_clip", last_clip, 1);

    // AC coupling from reset on ch1
    reset_dut();
    send(1, 3000 << 4, 1, 5, 0);
    drain();
    chk("ac_first_y", last_y, 121);
    chk("ac_first_ch", last_ch, 1);
    for (int i = 1; i < 4096; i++) send(1, 3000 << 4, 1, 5, 0);
    drain();
    chk("ac_converge", (last_y >= 239 && last_y <= 241), 1);
    send(0, 3000 << 4, 1, 5, 0);
    drain();
    chk("ac_ch0_untouched", last_y, 121);

    // Backpressure: 10 alternating samples, out_ready low for 5 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 10; i++) send(i % 2, (i * 6151 + 77) & 'hFFFF, 0, i % 4, i * 3 - 12);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap = {out_valid, out_ch, out_y};
        for (int j = 0; j < 5; j++) begin
          if (j != 0) @(negedge clk);
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_out_stable", {out_valid, out_ch, out_y}, snap);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with samples in flight; estimators must return to mid-scale
    send(0, 4000 << 4, 1, 5, 0);
    send(1, 100 << 4, 1, 5, 0);
    drain();
    send(0, 4000 << 4, 1, 5, 0);
    send(1, 100 << 4, 1, 5, 0);
    send(0, 4000 << 4, 1, 5, 0);
    reset_dut();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("flush_no_output", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(1, 3000 << 4, 1, 5, 0);
    drain();
    chk("est1_reset_y", last_y, 121);
    send(0, 3000 << 4, 1, 5, 0);
    drain();
    chk("est0_reset_y", last_y, 121);
    // in_ch is one bit wide at NUM_CH = 2, so an out-of-range channel cannot be driven here.

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
